fdiv_opq: RTL and testbench

Operand queue and pre-classifier that sits directly upstream of the combinational `fdiv` divider. It accepts dividend/divisor pairs over a valid/ready handshake and buffers them in a DEPTH-entry FIFO. At enqueue it classifies each operand and precomputes the sign and the signed exponent difference, so the divider and its special-case logic receive registered, pre-decoded operands. It also absorbs back-pressure from the downstream result path.

---
 rtl/fdiv_pkg.sv | 39 +++
 rtl/fp_classify.sv | 38 +++
 rtl/fdiv_opq.sv | 127 ++++++++++++
 tb/tb_fdiv_opq.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/fdiv_pkg.sv
// Shared types and format helpers for the fdiv operand path.
// Field-size functions let the queue and the downstream divider agree on a layout for a given N.
package fdiv_pkg;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    SUB  = 3'd1,
    NORM = 3'd2,
    INF  = 3'd3,
    NAN  = 3'd4
  } cls_t;

  function automatic int exp_len_f(input int n);
    if (n == 64) return 11;
    else         return 8;
  endfunction

  function automatic int man_len_f(input int n);
    if (n == 64) return 52;
    else         return 23;
  endfunction

  function automatic int exp_hi_f(input int n);
    return n - 2;
  endfunction

  function automatic int man_hi_f(input int n);
    return man_len_f(n) - 1;
  endfunction

  // Any operand class that routes the divider into its special-case path
  function automatic logic is_special_f(input cls_t c);
    case (c)
      ZERO, INF, NAN: return 1'b1;
      default:        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational IEEE-754 operand decoder: splits sign/exponent/mantissa and
// assigns the operand class.
module fp_classify
  import fdiv_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0]            op,
  output logic                    sign,
  output cls_t                    cls,
  output logic [exp_len_f(N)-1:0] exp,
  output logic [man_len_f(N)-1:0] man
);

  localparam int EXP_LEN = exp_len_f(N);
  localparam int MAN_LEN = man_len_f(N);
  localparam int EXP_HI  = exp_hi_f(N);
  localparam int MAN_HI  = man_hi_f(N);

  assign sign = op[N-1];
  assign exp  = op[EXP_HI -: EXP_LEN];
  assign man  = op[MAN_HI:0];

  // Class decode from the exponent and mantissa fields
  always_comb begin
    cls = NORM;
    if (exp == {EXP_LEN{1'b0}}) begin
      if (man == {MAN_LEN{1'b0}}) cls = ZERO;
      else                        cls = SUB;
    end else if (exp == {EXP_LEN{1'b1}}) begin
      if (man == {MAN_LEN{1'b0}}) cls = INF;
      else                        cls = NAN;
    end else begin
      cls = NORM;
    end
  end

endmodule

// File: rtl/fdiv_opq.sv
// Operand queue for the fdiv divider: classifies both operands at enqueue and
// buffers the pre-decoded pair in a DEPTH-entry FIFO.
module fdiv_opq
  import fdiv_pkg::*;
#(
  parameter int N     = 32,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N-1:0]              in_a,
  input  logic [N-1:0]              in_b,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N-1:0]              out_a,
  output logic [N-1:0]              out_b,
  output cls_t                      out_cls_a,
  output cls_t                      out_cls_b,
  output logic                      out_sign,
  output logic [exp_len_f(N):0]     out_ediff,
  output logic                      out_special,
  output logic [$clog2(DEPTH):0]    count,
  output logic [7:0]                drop_cnt
);

  localparam int EXP_LEN = exp_len_f(N);
  localparam int MAN_LEN = man_len_f(N);
  localparam int AW      = $clog2(DEPTH);
  localparam int PW      = AW + 1;
  localparam int ED_W    = EXP_LEN + 1;

  // Packed entry layout, LSB first: special, ediff, sign, cls_b, cls_a, b, a
  localparam int ED_LSB  = 1;
  localparam int SG_LSB  = ED_LSB + ED_W;
  localparam int CB_LSB  = SG_LSB + 1;
  localparam int CA_LSB  = CB_LSB + 3;
  localparam int B_LSB   = CA_LSB + 3;
  localparam int A_LSB   = B_LSB + N;
  localparam int ENTRY_W = A_LSB + N;

  if (!(N == 32 || N == 64)) begin : g_bad_n
    $fatal(1, "fdiv_opq: N must be 32 or 64");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "fdiv_opq: DEPTH must be a power of two >= 2");
  end

  logic                 sign_a_s, sign_b_s;
  cls_t                 cls_a_s, cls_b_s;
  logic [EXP_LEN-1:0]   exp_a_s, exp_b_s;
  logic [MAN_LEN-1:0]   man_a_s, man_b_s;
  logic [ED_W-1:0]      ediff_s;
  logic                 special_s;
  logic [ENTRY_W-1:0]   entry_s;
  logic [ENTRY_W-1:0]   head_s;

  logic [ENTRY_W-1:0]   mem_r [DEPTH];
  logic [PW-1:0]        wr_ptr_r, rd_ptr_r, count_r;
  logic [7:0]           drop_cnt_r;
  logic                 full_s, empty_s, push_s, pop_s;

  fp_classify #(.N(N)) u_cls_a (
    .op(in_a), .sign(sign_a_s), .cls(cls_a_s), .exp(exp_a_s), .man(man_a_s)
  );
  fp_classify #(.N(N)) u_cls_b (
    .op(in_b), .sign(sign_b_s), .cls(cls_b_s), .exp(exp_b_s), .man(man_b_s)
  );

  // Zero-extended subtraction: the extra bit keeps the difference from wrapping
  assign ediff_s   = {1'b0, exp_a_s} - {1'b0, exp_b_s};
  assign special_s = is_special_f(cls_a_s) | is_special_f(cls_b_s);
  assign entry_s   = {sign_a_s, exp_a_s, man_a_s, sign_b_s, exp_b_s, man_b_s,
                      cls_a_s, cls_b_s, sign_a_s ^ sign_b_s, ediff_s, special_s};

  assign empty_s = (wr_ptr_r == rd_ptr_r);
  assign full_s  = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) && (wr_ptr_r[AW] != rd_ptr_r[AW]);
  assign push_s  = in_valid & ~full_s & ~flush;
  assign pop_s   = ~empty_s & out_ready & ~flush;

  // Entry storage; contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r[AW-1:0]] <= entry_s;
  end

  // Pointers and occupancy; rst beats flush, flush beats push/pop
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {PW{1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      if (pop_s)  rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + {{AW{1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{AW{1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

  // Saturating count of refused offers; only rst clears it
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_r <= 8'd0;
    end else if (in_valid && full_s && drop_cnt_r != 8'hFF) begin
      drop_cnt_r <= drop_cnt_r + 8'd1;
    end
  end

  assign head_s      = mem_r[rd_ptr_r[AW-1:0]];
  assign in_ready    = ~full_s;
  assign out_valid   = ~empty_s;
  assign count       = count_r;
  assign drop_cnt    = drop_cnt_r;
  assign out_a       = head_s[A_LSB +: N];
  assign out_b       = head_s[B_LSB +: N];
  assign out_cls_a   = cls_t'(head_s[CA_LSB +: 3]);
  assign out_cls_b   = cls_t'(head_s[CB_LSB +: 3]);
  assign out_sign    = head_s[SG_LSB];
  assign out_ediff   = head_s[ED_LSB +: ED_W];
  assign out_special = head_s[0];

endmodule

// File: tb/tb_fdiv_opq.sv
// Directed self-checking bench for fdiv_opq (N=32, DEPTH=4).
module tb_fdiv_opq;
  import fdiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_a, in_b;
  logic        in_ready, out_valid, out_sign, out_special;
  logic [31:0] out_a, out_b;
  cls_t        out_cls_a, out_cls_b;
  logic [8:0]  out_ediff;
  logic [2:0]  count;
  logic [7:0]  drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  fdiv_opq #(.N(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_cls_a(out_cls_a), .out_cls_b(out_cls_b),
    .out_sign(out_sign), .out_ediff(out_ediff), .out_special(out_special),
    .count(count), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = 32'd0; in_b = 32'd0;
    tick(); tick();
    rst = 1'b0;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
    n_checks++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_drop got %0d want 0", drop_cnt); end
  endtask

  task automatic test_single();
    in_valid = 1'b1; in_a = 32'h3F80_0000; in_b = 32'h4000_0000;
    tick();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b want 1", out_valid); end
    n_checks++; if (out_cls_a !== NORM || out_cls_b !== NORM) begin n_fail++; $display("FAIL single_cls got %0d/%0d want 2/2", out_cls_a, out_cls_b); end
    n_checks++; if (out_ediff !== 9'h1FF) begin n_fail++; $display("FAIL single_ediff got %h want 1ff", out_ediff); end
    n_checks++; if (out_sign !== 1'b0 || out_special !== 1'b0) begin n_fail++; $display("FAIL single_sign_special got %b%b want 00", out_sign, out_special); end
    n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL single_count got %0d want 1", count); end
    n_checks++; if (out_a !== 32'h3F80_0000 || out_b !== 32'h4000_0000) begin n_fail++; $display("FAIL single_data got %h/%h", out_a, out_b); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    n_checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL single_pop got count %0d valid %b want 0 0", count, out_valid); end
  endtask

  task automatic test_special();
    in_valid = 1'b1; in_a = 32'h7F80_0000; in_b = 32'h0000_0000; tick();
    in_a = 32'h7FC0_0000; in_b = 32'h0000_0001; tick();
    in_a = 32'hC000_0000; in_b = 32'h3F80_0000; tick();
    in_valid = 1'b0;
    n_checks++; if (out_cls_a !== INF || out_cls_b !== ZERO) begin n_fail++; $display("FAIL spec1_cls got %0d/%0d want 3/0", out_cls_a, out_cls_b); end
    n_checks++; if (out_special !== 1'b1 || out_ediff !== 9'h0FF) begin n_fail++; $display("FAIL spec1_sp_ed got %b %h want 1 0ff", out_special, out_ediff); end
    out_ready = 1'b1; tick();
    n_checks++; if (out_cls_a !== NAN || out_cls_b !== SUB) begin n_fail++; $display("FAIL spec2_cls got %0d/%0d want 4/1", out_cls_a, out_cls_b); end
    n_checks++; if (out_special !== 1'b1 || out_ediff !== 9'h0FF) begin n_fail++; $display("FAIL spec2_sp_ed got %b %h want 1 0ff", out_special, out_ediff); end
    tick();
    n_checks++; if (out_sign !== 1'b1 || out_ediff !== 9'h001 || out_special !== 1'b0) begin n_fail++; $display("FAIL neg_pair got sign %b ed %h sp %b want 1 001 0", out_sign, out_ediff, out_special); end
    tick(); out_ready = 1'b0;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL spec_drain got %0d want 0", count); end
  endtask

  task automatic test_fill_drop();
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_a = 32'h4000_0000 + i; in_b = 32'h3F80_0000 + i;
      tick();
      n_checks++; if (out_a !== 32'h4000_0000) begin n_fail++; $display("FAIL hold_stable got %h want 40000000", out_a); end
    end
    in_valid = 1'b0;
    n_checks++; if (in_ready !== 1'b0 || count !== 3'd4) begin n_fail++; $display("FAIL fill_full got ready %b count %0d want 0 4", in_ready, count); end
    n_checks++; if (drop_cnt !== 8'd2) begin n_fail++; $display("FAIL fill_drop got %0d want 2", drop_cnt); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (out_a !== 32'h4000_0000 + i || out_b !== 32'h3F80_0000 + i) begin n_fail++; $display("FAIL fill_order%0d got %h/%h", i, out_a, out_b); end
      tick();
    end
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fill_empty got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] q[$];
    logic [31:0] nxt;
    nxt = 32'h1000_0000;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_a = nxt; in_b = ~nxt; tick(); q.push_back(nxt); nxt++;
    end
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1; in_a = nxt; in_b = ~nxt; out_ready = 1'b1;
      n_checks++; if (in_ready !== 1'b0 || out_a !== q[0]) begin n_fail++; $display("FAIL b2b_head%0d got ready %b a %h want 0 %h", i, in_ready, out_a, q[0]); end
      tick(); void'(q.pop_front());
      n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL b2b_pop%0d got %0d want 3", i, count); end
      out_ready = 1'b0; tick(); q.push_back(nxt); nxt++;
      n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL b2b_push%0d got %0d want 4", i, count); end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (out_a !== q[i] || out_b !== ~q[i]) begin n_fail++; $display("FAIL b2b_drain%0d got %h want %h", i, out_a, q[i]); end
      tick();
    end
    out_ready = 1'b0;
    n_checks++; if (drop_cnt !== 8'd14) begin n_fail++; $display("FAIL b2b_drop got %0d want 14", drop_cnt); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_a = 32'h4100_0000 + i; in_b = 32'h3F00_0000; tick();
    end
    flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    n_checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_clear got count %0d valid %b want 0 0", count, out_valid); end
    n_checks++; if (drop_cnt !== 8'd14 || in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_drop got %0d ready %b want 14 1", drop_cnt, in_ready); end
  endtask

  task automatic test_sat_reset();
    in_valid = 1'b1; in_a = 32'h4200_0000; in_b = 32'h4200_0000;
    for (int i = 0; i < 304; i++) tick();
    in_valid = 1'b0;
    n_checks++; if (drop_cnt !== 8'd255 || count !== 3'd4) begin n_fail++; $display("FAIL sat_drop got %0d count %0d want 255 4", drop_cnt, count); end
    out_ready = 1'b1; tick(); tick(); out_ready = 1'b0;
    n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL sat_two got %0d want 2", count); end
    rst = 1'b1; tick(); rst = 1'b0;
    n_checks++; if (count !== 3'd0 || drop_cnt !== 8'd0) begin n_fail++; $display("FAIL midrst got count %0d drop %0d want 0 0", count, drop_cnt); end
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_hs got ready %b valid %b want 1 0", in_ready, out_valid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_special();
    test_fill_drop();
    test_back_to_back();
    test_flush();
    test_sat_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
